// File: rtl/switch_sequencer_if.sv
// Host/switcher-facing bundle for switch_sequencer.
//   master : host side; drives pattern writes and run control, observes status.
//   slave  : sequencer side; consumes host controls, drives bank enables/status.
// Signals:
//   pat_wr_en/pat_wr_addr/pat_wr_data : pattern memory write port
//   num_symbols                       : run length, sampled on an accepted start
//   start/abort                       : run control
//   bank_en                           : enables to the switcher instances
//   busy/sample_strobe/symbol_idx/done: run status
interface switch_sequencer_if #(
  parameter int NUM_BANKS   = 4,
  parameter int PATTERN_LEN = 32
);
  logic                             pat_wr_en;
  logic [$clog2(PATTERN_LEN)-1:0]   pat_wr_addr;
  logic [NUM_BANKS-1:0]             pat_wr_data;
  logic [$clog2(PATTERN_LEN+1)-1:0] num_symbols;
  logic                             start;
  logic                             abort;
  logic [NUM_BANKS-1:0]             bank_en;
  logic                             busy;
  logic                             sample_strobe;
  logic [$clog2(PATTERN_LEN)-1:0]   symbol_idx;
  logic                             done;

  modport master (
    output pat_wr_en, pat_wr_addr, pat_wr_data, num_symbols, start, abort,
    input  bank_en, busy, sample_strobe, symbol_idx, done
  );

  modport slave (
    input  pat_wr_en, pat_wr_addr, pat_wr_data, num_symbols, start, abort,
    output bank_en, busy, sample_strobe, symbol_idx, done
  );
endinterface

// File: rtl/switch_sequencer.sv
// switch_sequencer: plays a host-written pattern of bank-enable words onto the
// switcher array, one word per SYMBOL_CYCLES-long slot, with a strobe on the
// first cycle of every slot for the ring-oscillator sampler.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : switch_sequencer_if.slave (pattern write port, run control, status)
// All outputs on bus are driven straight from flops.
module switch_sequencer #(
  parameter int NUM_BANKS     = 4,
  parameter int PATTERN_LEN   = 32,
  parameter int SYMBOL_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  switch_sequencer_if.slave bus
);

  localparam int AW = $clog2(PATTERN_LEN);
  localparam int NW = $clog2(PATTERN_LEN + 1);
  localparam int CW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SYMBOL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the final word of a run: min(n, PATTERN_LEN) - 1.
  // Only called with n != 0.
  function automatic logic [AW-1:0] sat_last(input logic [NW-1:0] n);
    logic [NW-1:0] sat;
    sat = (n > NW'(PATTERN_LEN)) ? NW'(PATTERN_LEN) : n;
    return AW'(sat - NW'(1));
  endfunction

  logic [NUM_BANKS-1:0] pat [PATTERN_LEN];

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [AW-1:0]        idx_inc;
  logic [AW-1:0]        last_q;
  logic                 load_last;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
  logic                 busy_q, busy_d;
  logic                 strobe_q, strobe_d;
  logic                 done_q, done_d;
  logic                 addr_ok;

  // Out-of-range addresses can only occur when PATTERN_LEN is not a power of 2.
  if ((1 << AW) == PATTERN_LEN) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (bus.pat_wr_addr < AW'(PATTERN_LEN));
  end

  // Pattern memory has no reset so contents survive rst; frozen while a run plays.
  always_ff @(posedge clk) begin
    if (bus.pat_wr_en && !busy_q && addr_ok) begin
      pat[bus.pat_wr_addr] <= bus.pat_wr_data;
    end
  end

  assign idx_inc = idx_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bank_en_d = bank_en_q;
    busy_d    = 1'b0;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    load_last = 1'b0;
    case (state_q)
      IDLE: begin
        bank_en_d = '0;
        idx_d     = '0;
        // abort has priority over start, including zero-length requests.
        if (bus.start && !bus.abort) begin
          if (bus.num_symbols != '0) begin
            state_d   = RUN;
            load_last = 1'b1;
            cnt_d     = CNT_RELOAD;
            bank_en_d = pat[0];
            busy_d    = 1'b1;
            strobe_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (bus.abort) begin
          state_d   = IDLE;
          bank_en_d = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (idx_q != last_q) begin
          idx_d     = idx_inc;
          cnt_d     = CNT_RELOAD;
          bank_en_d = pat[idx_inc];
          strobe_d  = 1'b1;
        end else begin
          state_d   = DONE;
          bank_en_d = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        bank_en_d = '0;
        idx_d     = '0;
      end
      default: begin
        state_d   = IDLE;
        bank_en_d = '0;
        idx_d     = '0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      bank_en_q <= '0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bank_en_q <= bank_en_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  // Run length is only meaningful in RUN and is reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (load_last) begin
      last_q <= sat_last(bus.num_symbols);
    end
  end

  assign bus.bank_en       = bank_en_q;
  assign bus.busy          = busy_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.symbol_idx    = idx_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Testbench for switch_sequencer (NUM_BANKS=4, PATTERN_LEN=8, SYMBOL_CYCLES=4).
// A behavioural model turns every accepted start into a busy window plus a list
// of strobe/done events; a negedge monitor checks levels every cycle and pops
// the event queue whenever the DUT raises sample_strobe or done.
module tb_switch_sequencer;

  localparam int NB = 4;
  localparam int PL = 8;
  localparam int S  = 4;

  typedef struct {
    bit            is_done;
    int            cyc;
    int            idx;
    logic [NB-1:0] word;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_sequencer_if #(.NUM_BANKS(NB), .PATTERN_LEN(PL)) bus ();

  switch_sequencer #(
    .NUM_BANKS(NB),
    .PATTERN_LEN(PL),
    .SYMBOL_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ev_t           evq[$];
  logic [NB-1:0] mpat [PL];
  logic [NB-1:0] snap [PL];
  int            rs = 1;
  int            re = 0;
  int            done_cyc = -1;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour for inputs held during interval c (sampled at its closing edge).
  function automatic void model_step(int c, bit st, int num, bit ab, bit we, int addr,
                                     logic [NB-1:0] data);
    bit in_run;
    bit in_done;
    int n;
    in_run  = (c >= rs) && (c <= re);
    in_done = (c == done_cyc);
    if (ab && in_run) begin
      re       = c;
      done_cyc = -1;
      while (evq.size() > 0 && evq[evq.size()-1].cyc > c) void'(evq.pop_back());
    end else if (st && !ab && !in_run && !in_done) begin
      n = (num > PL) ? PL : num;
      if (n == 0) begin
        done_cyc = c + 1;
        evq.push_back('{1'b1, c + 1, 0, 4'h0});
      end else begin
        for (int k = 0; k < PL; k++) snap[k] = mpat[k];
        rs       = c + 1;
        re       = c + n * S;
        done_cyc = c + n * S + 1;
        for (int k = 0; k < n; k++) evq.push_back('{1'b0, c + 1 + k * S, k, mpat[k]});
        evq.push_back('{1'b1, done_cyc, 0, 4'h0});
      end
    end
    if (we && !in_run && addr < PL) mpat[addr] = data;
  endfunction

  // Asynchronous reset asserted during interval c kills the run from c onward.
  function automatic void model_reset(int c);
    if (re >= c) re = c - 1;
    if (done_cyc >= c) done_cyc = -1;
    while (evq.size() > 0 && evq[evq.size()-1].cyc >= c) void'(evq.pop_back());
  endfunction

  task automatic drive(input bit st, input int num, input bit ab, input bit we,
                       input int addr, input logic [NB-1:0] data);
    bus.start       = st;
    bus.num_symbols = 4'(num);
    bus.abort       = ab;
    bus.pat_wr_en   = we;
    bus.pat_wr_addr = 3'(addr);
    bus.pat_wr_data = data;
    if (!rst) model_step(cyc, st, num, ab, we, addr, data);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.pat_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 0, 4'h0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((cyc <= re || cyc <= done_cyc) && guard < 200) begin
      idle(1);
      guard++;
    end
    chk("run_finished_in_bound", 64'(guard < 200), 64'd1);
    idle(1);
  endtask

  always @(negedge clk) begin
    bit  in_run;
    int  k;
    ev_t e;
    in_run = (cyc >= rs) && (cyc <= re);
    k      = in_run ? (cyc - rs) / S : 0;
    chk("busy", 64'(bus.busy), 64'(in_run));
    chk("bank_en", 64'(bus.bank_en), in_run ? 64'(snap[k]) : 64'd0);
    if (in_run || rst) chk("symbol_idx", 64'(bus.symbol_idx), 64'(k));
    if (bus.sample_strobe === 1'b1 || bus.done === 1'b1) begin
      if (evq.size() == 0) begin
        chk("unexpected_event", 64'({bus.sample_strobe, bus.done}), 64'd0);
      end else begin
        e = evq.pop_front();
        chk(e.is_done ? "done_event" : "strobe_event",
            {18'd0, 32'(cyc), bus.done, bus.sample_strobe,
             (e.is_done ? 8'd0 : 8'(bus.symbol_idx)), bus.bank_en},
            {18'd0, 32'(e.cyc), e.is_done, ~e.is_done, 8'(e.idx), e.word});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] init_pat [PL];
    bit st;
    bit ab;
    bit we;
    init_pat = '{4'h1, 4'h3, 4'hF, 4'h5, 4'h6, 4'h9, 4'hC, 4'h7};
    bus.start       = 1'b0;
    bus.num_symbols = '0;
    bus.abort       = 1'b0;
    bus.pat_wr_en   = 1'b0;
    bus.pat_wr_addr = '0;
    bus.pat_wr_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Load pattern, then a 3-symbol run; starts during the last busy cycle and DONE are ignored.
    for (int a = 0; a < PL; a++) drive(1'b0, 0, 1'b0, 1'b1, a, init_pat[a]);
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    idle(11);
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    wait_idle();

    // Zero-length run.
    drive(1'b1, 0, 1'b0, 1'b0, 0, 4'h0);
    wait_idle();

    // Over-length request saturates to PATTERN_LEN symbols.
    drive(1'b1, 12, 1'b0, 1'b0, 0, 4'h0);
    wait_idle();

    // Abort mid-run, then start+abort together in IDLE.
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    idle(5);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 4'h0);
    idle(2);
    drive(1'b1, 3, 1'b1, 1'b0, 0, 4'h0);
    idle(3);

    // Write while busy is dropped; a start during the run has no effect.
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    idle(1);
    drive(1'b0, 0, 1'b0, 1'b1, 1, 4'hA);
    drive(1'b1, 5, 1'b0, 1'b0, 0, 4'h0);
    wait_idle();
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    wait_idle();

    // Reset mid-run; pattern survives.
    drive(1'b1, 3, 1'b0, 1'b0, 0, 4'h0);
    idle(6);
    rst = 1'b1;
    model_reset(cyc);
    idle(2);
    rst = 1'b0;
    idle(1);
    drive(1'b1, 1, 1'b0, 1'b0, 0, 4'h0);
    wait_idle();

    // Randomised traffic.
    repeat (1500) begin
      st = ($urandom_range(0, 9) == 0);
      ab = ($urandom_range(0, 79) == 0);
      we = !st && ($urandom_range(0, 4) == 0);
      drive(st, $urandom_range(0, 12), ab, we, $urandom_range(0, PL - 1), 4'($urandom));
    end
    wait_idle();

    chk("event_queue_drained", 64'(evq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_sequencer.md
# switch_sequencer

Sequencer for the on-chip switching-activity banks. It holds a host-written pattern of bank-enable words and plays it out, one word per fixed-length symbol slot, onto the `en` inputs of `NUM_BANKS` switcher instances. At every symbol boundary it emits a strobe so the ring-oscillator sampler can timestamp each trace segment. It sits between the host register interface and the switcher array.

## Interface
Parameters:
- `NUM_BANKS`, default 4: number of switcher banks driven; width of each pattern word.
- `PATTERN_LEN`, default 32: depth of the pattern memory, in words.
- `SYMBOL_CYCLES`, default 1000: clock cycles each pattern word is held; must be ≥ 1.

Ports (all outputs registered):
- `clk` in 1: clock `clk`.
- `rst` in 1: reset `rst`, asynchronous, active-high.
- `pat_wr_en` in 1: pattern memory write strobe.
- `pat_wr_addr` in `$clog2(PATTERN_LEN)`: write address.
- `pat_wr_data` in `NUM_BANKS`: bank-enable word; bit i drives bank i.
- `num_symbols` in `$clog2(PATTERN_LEN+1)`: symbols to play; sampled only on an accepted `start`.
- `start` in 1: single-cycle run request.
- `abort` in 1: terminate the run immediately.
- `bank_en` out `NUM_BANKS`: enables to the switcher instances.
- `busy` out 1: high while in RUN.
- `sample_strobe` out 1: one-cycle pulse on the first cycle of each symbol.
- `symbol_idx` out `$clog2(PATTERN_LEN)`: index of the word currently on `bank_en`.
- `done` out 1: one-cycle pulse when a run completes normally.

## Operation
- Pattern memory is `PATTERN_LEN` × `NUM_BANKS`, written synchronously.
  - A write is ignored while `busy`=1.
  - A write with `pat_wr_addr` ≥ `PATTERN_LEN` is ignored.
  - Contents survive `rst`; no read port.
- Registers:
  - `state` ∈ {IDLE, RUN, DONE}.
  - `cnt`: width `$clog2(SYMBOL_CYCLES)`, minimum 1 bit.
  - `idx`.
  - `last`: the latched `num_symbols`, saturated to `PATTERN_LEN`, minus 1.
- IDLE:
  - Outputs: `bank_en`=0, `busy`=0, `done`=0, `sample_strobe`=0.
  - `start`=1, `abort`=0 and `num_symbols`≠0: latch `last`, set `idx`=0 and `cnt`=`SYMBOL_CYCLES`-1, load `bank_en`=pat[0], assert `sample_strobe`, go to RUN.
  - `start`=1 and `num_symbols`=0: go to DONE; no bank is enabled.
  - `start`=1 and `abort`=1 in the same cycle: `abort` wins and the block stays in IDLE.
- RUN:
  - `busy`=1.
  - `abort`=1: next cycle goes to IDLE with `bank_en`=0 and no `done` pulse.
  - Else if `cnt`≠0: `cnt` decrements and `bank_en` holds.
  - Else if `idx`≠`last`: `idx`+1, reload `cnt`, load `bank_en`=pat[`idx`+1], assert `sample_strobe`.
  - Else (`cnt`=0 and `idx`=`last`): go to DONE with `bank_en`=0.
- DONE:
  - `done`=1 for exactly one cycle, `busy`=0, `bank_en`=0.
  - Unconditionally go to IDLE.
  - A `start` seen in DONE is ignored.
- `start` while in RUN is ignored.
- Any illegal state encoding recovers to IDLE with all outputs 0.
- `rst`, including mid-run:
  - The next state is IDLE.
  - `bank_en`=0, `busy`=0, `sample_strobe`=0, `done`=0, `symbol_idx`=0.
  - No `done` pulse is produced.

## Timing
- Let `start` be sampled at edge T with N = min(`num_symbols`, `PATTERN_LEN`).
  - Word k is on `bank_en` for cycles T+1+k·S through T+(k+1)·S, where S=`SYMBOL_CYCLES`.
  - `sample_strobe` is high at cycles T+1+k·S.
  - `busy` is high for cycles T+1 … T+N·S.
  - `done` is high at T+N·S+1. The earliest next accepted `start` is sampled at T+N·S+2.
- With S=1: `bank_en` changes every cycle and `sample_strobe` stays high for N consecutive cycles.
- `abort` sampled at edge A: `bank_en`=0 and `busy`=0 from cycle A+1.
- Zero-length run: `done` pulses at T+1; `busy` never asserts.
- `symbol_idx` updates in the same cycle as `bank_en`.

## Test plan
Bench configuration: `NUM_BANKS`=4, `PATTERN_LEN`=8, `SYMBOL_CYCLES`=4.

1. Write pat = {0x1, 0x3, 0xF}; `start` with `num_symbols`=3 at T. Expected: `bank_en` is 0x1 at T+1..4, 0x3 at T+5..8, 0xF at T+9..12; `sample_strobe` at T+1, T+5, T+9; `done` at T+13; `busy` high for 12 cycles.
2. `num_symbols`=0. Expected: `done` at T+1, `bank_en` stays 0, `busy` stays 0.
3. `num_symbols`=12. Expected: the run saturates at 8 symbols and `done` is at T+33.
4. `abort` at T+6 during scenario 1. Expected: `bank_en`=0 and `busy`=0 at T+7, and no `done`. Then `start` and `abort` in the same IDLE cycle. Expected: no run.
5. Pattern write to address 1 with 0xA while `busy`. Expected: the write is ignored and the next run still plays 0x3 at index 1. Also `start` pulsed at T+3 during a run. Expected: no effect on timing.
6. Assert `rst` at T+7 mid-run. Expected: all outputs are 0 immediately. After release, a new `start` plays pat[0] with the original contents intact.
